rf_host_config_sequencer: RTL

//  Host-side sequencer upstream of the RF transceiver. Drives M0/M1, watches AUX and emits
//  the 6-byte parameter packet (HEAD,ADDH,ADDL,SPED,CHAN,OPTION) as a byte stream into the

---
 rtl/rf_host_config_sequencer_if.sv | 42 ++++
 rtl/rf_host_config_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_host_config_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_host_config_sequencer_if
//  Description : Host-side bundle for the RF config sequencer. Carries the
//                command/payload request, the status strobes and the byte
//                stream towards the host UART TX.
//  Revision    : 1.0  initial release
// ============================================================================
interface rf_host_config_sequencer_if;
    logic       cmd_start;
    logic       cmd_config;
    logic       cmd_volatile;
    logic [1:0] cmd_run_mode;
    logic [7:0] cfg_addh;
    logic [7:0] cfg_addl;
    logic [7:0] cfg_sped;
    logic [7:0] cfg_chan;
    logic [7:0] cfg_option;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;

    // Host / UART side: issues commands, accepts bytes
    modport master (
        output cmd_start, cmd_config, cmd_volatile, cmd_run_mode,
        output cfg_addh, cfg_addl, cfg_sped, cfg_chan, cfg_option,
        output tx_ready,
        input  tx_data, tx_valid, busy, done, error
    );

    // Sequencer side
    modport slave (
        input  cmd_start, cmd_config, cmd_volatile, cmd_run_mode,
        input  cfg_addh, cfg_addl, cfg_sped, cfg_chan, cfg_option,
        input  tx_ready,
        output tx_data, tx_valid, busy, done, error
    );
endinterface
`default_nettype wire

// File: rtl/rf_host_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rf_host_config_sequencer
//  Description : Drives the transceiver M0/M1 pins, watches AUX and streams
//                the 6-byte parameter packet (HEAD,ADDH,ADDL,SPED,CHAN,OPTION)
//                into the host UART TX. Also performs plain mode switches.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_host_config_sequencer #(
    parameter logic [7:0]  HEAD_DETECT_1  = 8'hC0,
    parameter logic [7:0]  HEAD_DETECT_2  = 8'hC2,
    parameter logic [1:0]  DEFAULT_MODE   = 2'd3,
    parameter int unsigned SETTLE_CYCLES  = 31250,
    parameter int unsigned BUSY_WINDOW    = 6511,
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  wire logic                 internal_clk,
    input  wire logic                 rst_n,
    input  wire logic                 AUX,
    output logic                      M0,
    output logic                      M1,
    rf_host_config_sequencer_if.slave bus
);

    localparam int unsigned WAIT_MAX = (SETTLE_CYCLES > BUSY_WINDOW) ? SETTLE_CYCLES : BUSY_WINDOW;
    localparam int          WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int          TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WINDOW_LAST = WAIT_W'(BUSY_WINDOW - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RDY  = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_EXIT_RDY  = 3'd5,
        ST_DONE      = 3'd6,
        ST_ABORT     = 3'd7
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              aux_meta;
    logic              aux_s;
    logic [1:0]        mode;
    logic [1:0]        run_mode_q;
    logic [7:0]        head_q;
    logic [7:0]        addh_q;
    logic [7:0]        addl_q;
    logic [7:0]        sped_q;
    logic [7:0]        chan_q;
    logic [7:0]        option_q;
    logic [2:0]        idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [7:0]        pkt_byte;
    logic              accept;
    logic              apply_run;
    logic              settle_ok;
    logic              tmo_hit;
    logic              handshake;
    logic              entering;
    logic              timed_state;

    // Settle needs SETTLE_CYCLES consecutive ready samples; this is the last one.
    assign settle_ok   = aux_s && (wait_cnt == SETTLE_LAST);
    assign timed_state = state inside {ST_WAIT_RDY, ST_SEND, ST_WAIT_DONE, ST_EXIT_RDY};
    assign tmo_hit     = timed_state && (tmo_cnt == TMO_LAST);
    assign handshake   = (state == ST_SEND) && bus.tx_ready;
    assign entering    = (state_nxt != state);

    assign bus.tx_valid = (state == ST_SEND);
    assign bus.tx_data  = (state == ST_SEND) ? pkt_byte : 8'h00;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_DONE);
    assign bus.error    = (state == ST_ABORT);
    assign M1           = mode[1];
    assign M0           = mode[0];

    // Bring the asynchronous AUX pin into the clock domain; it idles "ready".
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            aux_meta <= 1'b1;
            aux_s    <= 1'b1;
        end else begin
            aux_meta <= AUX;
            aux_s    <= aux_meta;
        end
    end

    // State register.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; progress wins over a timeout landing on the same cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        apply_run = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_start) begin
                    accept    = 1'b1;
                    state_nxt = bus.cmd_config ? ST_WAIT_RDY : ST_EXIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (settle_ok)    state_nxt = ST_SEND;
                else if (tmo_hit) state_nxt = ST_ABORT;
            end
            ST_SEND: begin
                if (handshake && (idx == 3'd5)) state_nxt = ST_WAIT_BUSY;
                else if (tmo_hit)               state_nxt = ST_ABORT;
            end
            ST_WAIT_BUSY: begin
                if (!aux_s || (wait_cnt == WINDOW_LAST)) state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (settle_ok) begin
                    state_nxt = ST_EXIT_RDY;
                    apply_run = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_EXIT_RDY: begin
                if (settle_ok)    state_nxt = ST_DONE;
                else if (tmo_hit) state_nxt = ST_ABORT;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // An abort always hands the transceiver back in the requested run mode.
        if ((state != ST_ABORT) && (state_nxt == ST_ABORT)) apply_run = 1'b1;
    end

    // Select the packet byte currently offered to the UART.
    always_comb begin
        pkt_byte = 8'h00;
        case (idx)
            3'd0:    pkt_byte = head_q;
            3'd1:    pkt_byte = addh_q;
            3'd2:    pkt_byte = addl_q;
            3'd3:    pkt_byte = sped_q;
            3'd4:    pkt_byte = chan_q;
            3'd5:    pkt_byte = option_q;
            default: pkt_byte = 8'h00;
        endcase
    end

    // Capture the request on acceptance so later input changes cannot corrupt the packet.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            run_mode_q <= 2'b00;
            head_q     <= 8'h00;
            addh_q     <= 8'h00;
            addl_q     <= 8'h00;
            sped_q     <= 8'h00;
            chan_q     <= 8'h00;
            option_q   <= 8'h00;
        end else if (accept) begin
            run_mode_q <= bus.cmd_run_mode;
            head_q     <= bus.cmd_volatile ? HEAD_DETECT_2 : HEAD_DETECT_1;
            addh_q     <= bus.cfg_addh;
            addl_q     <= bus.cfg_addl;
            sped_q     <= bus.cfg_sped;
            chan_q     <= bus.cfg_chan;
            option_q   <= bus.cfg_option;
        end
    end

    // Mode pins: config mode (or direct run mode) on accept, run mode at the end or on abort.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= DEFAULT_MODE;
        end else if (accept) begin
            mode <= bus.cmd_config ? 2'b11 : bus.cmd_run_mode;
        end else if (apply_run) begin
            mode <= run_mode_q;
        end
    end

    // Packet byte index; advances on each accepted byte and parks on the last one.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 3'd0;
        end else if (accept) begin
            idx <= 3'd0;
        end else if (handshake && (idx != 3'd5)) begin
            idx <= idx + 3'd1;
        end
    end

    // Settle / busy-window counter, restarted on every state change.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (entering) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT_BUSY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else if (state inside {ST_WAIT_RDY, ST_WAIT_DONE, ST_EXIT_RDY}) begin
            wait_cnt <= aux_s ? (wait_cnt + 1'b1) : '0;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Timeout counter, restarted on every state change, runs only in guarded states.
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (entering || !timed_state) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
